// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if
//   Bundles the descriptor-config port, the run/status handshake and the
//   matmul-engine control signals of nn_layer_sequencer.
//   slave  : sequencer view (config/run/mm_done in, engine controls + status out)
//   master : host / engine / memory view (the mirror image)
//   Signals:
//     cfg_we, cfg_addr[LW-1:0], cfg_data[45:0]  descriptor write port
//     num_layers[LW:0], run                     run request
//     mm_m/mm_n/mm_k[9:0], mm_start, mm_done    engine control
//     weight_base[15:0], act_rd_bank, act_wr_bank, layer_idx[LW-1:0]
//     busy, done, err                           status
//   NN_SEQ_RELU_EN adds relu_addr[15:0], relu_rd_data[31:0] (signed),
//   relu_wr_data[31:0], relu_we.
interface nn_layer_sequencer_if #(
    parameter int LW = 3
);
    logic              cfg_we;
    logic [LW-1:0]     cfg_addr;
    logic [45:0]       cfg_data;
    logic [LW:0]       num_layers;
    logic              run;
    logic [9:0]        mm_m;
    logic [9:0]        mm_n;
    logic [9:0]        mm_k;
    logic              mm_start;
    logic              mm_done;
    logic [15:0]       weight_base;
    logic              act_rd_bank;
    logic              act_wr_bank;
    logic [LW-1:0]     layer_idx;
    logic              busy;
    logic              done;
    logic              err;
`ifdef NN_SEQ_RELU_EN
    logic [15:0]       relu_addr;
    logic signed [31:0] relu_rd_data;
    logic [31:0]       relu_wr_data;
    logic              relu_we;
`endif

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_layers, run, mm_done,
        output mm_m, mm_n, mm_k, mm_start, weight_base, act_rd_bank,
               act_wr_bank, layer_idx, busy, done, err
`ifdef NN_SEQ_RELU_EN
        ,
        input  relu_rd_data,
        output relu_addr, relu_wr_data, relu_we
`endif
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_layers, run, mm_done,
        input  mm_m, mm_n, mm_k, mm_start, weight_base, act_rd_bank,
               act_wr_bank, layer_idx, busy, done, err
`ifdef NN_SEQ_RELU_EN
        ,
        output relu_rd_data,
        input  relu_addr, relu_wr_data, relu_we
`endif
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
//   Runs up to MAX_LAYERS fully-connected layers on the shared matmul engine.
//   A descriptor table (weight_base, m, n, k per layer) is written over the
//   config port while idle. Each layer: LOAD dims, START pulse, ARM (stale
//   engine done ignored), WAIT for mm_done, optional RELU pass, NEXT.
//   Activation banks ping-pong per executed layer; skipped layers
//   (zero dimension) do not swap banks and set the sticky err flag.
//   Ports:
//     clk_i    rising-edge clock
//     reset_i  asynchronous active-high reset
//     bus      nn_layer_sequencer_if.slave (config, run, engine, status)
//   Optional feature macro: NN_SEQ_RELU_EN (in-place ReLU over the layer's
//   m*n outputs in bank act_wr_bank, via the relu_* interface signals).
module nn_layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int LW         = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    nn_layer_sequencer_if.slave  bus
);

`ifdef NN_SEQ_RELU_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_ARM, S_WAIT, S_NEXT, S_DONE, S_RELU
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_ARM, S_WAIT, S_NEXT, S_DONE
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [LW:0]     count_q, count_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic            bank_q, bank_d;
    logic            err_q, err_d;
    logic            skip_q, skip_d;
    logic [9:0]      m_q, m_d, n_q, n_d, k_q, k_d;
    logic [15:0]     wb_q, wb_d;
    logic [45:0]     table_q [MAX_LAYERS];

    logic [45:0]     ent;
    logic            ent_zero;
    logic            run_ok;
    logic            last;
    logic            cfg_wr;

`ifdef NN_SEQ_RELU_EN
    logic [19:0]     cnt_q, cnt_d;
    logic [19:0]     mn;
    assign mn = 20'(m_q) * 20'(n_q);
`endif

    assign ent      = table_q[layer_q];
    assign ent_zero = (ent[29:20] == '0) || (ent[19:10] == '0) || (ent[9:0] == '0);
    assign run_ok   = (bus.num_layers != '0) &&
                      (bus.num_layers <= (LW+1)'(MAX_LAYERS));
    assign last     = ({1'b0, layer_q} == (count_q - (LW+1)'(1)));
    // Table is writable whenever busy is low (IDLE and the DONE cycle).
    assign cfg_wr   = bus.cfg_we && ((state_q == S_IDLE) || (state_q == S_DONE));

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.run && run_ok) state_d = S_LOAD;
            S_LOAD:  state_d = ent_zero ? S_NEXT : S_START;
            S_START: state_d = S_ARM;
            S_ARM:   state_d = S_WAIT;
`ifdef NN_SEQ_RELU_EN
            S_WAIT:  if (bus.mm_done) state_d = S_RELU;
            S_RELU:  if (cnt_q == mn) state_d = S_NEXT;
`else
            S_WAIT:  if (bus.mm_done) state_d = S_NEXT;
`endif
            S_NEXT:  state_d = last ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        count_d = count_q;
        layer_d = layer_q;
        bank_d  = bank_q;
        err_d   = err_q;
        skip_d  = skip_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        wb_d    = wb_q;
`ifdef NN_SEQ_RELU_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    if (run_ok) begin
                        count_d = bus.num_layers;
                        layer_d = '0;
                        bank_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                wb_d   = ent[45:30];
                m_d    = ent[29:20];
                n_d    = ent[19:10];
                k_d    = ent[9:0];
                skip_d = ent_zero;
                if (ent_zero) err_d = 1'b1;
            end
`ifdef NN_SEQ_RELU_EN
            S_WAIT: cnt_d = '0;
            S_RELU: cnt_d = cnt_q + 20'd1;
`endif
            S_NEXT: begin
                if (!last) begin
                    layer_d = layer_q + LW'(1);
                    // A skipped layer produced no output, so the banks stay put.
                    if (!skip_q) bank_d = ~bank_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            layer_q <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            wb_q    <= '0;
`ifdef NN_SEQ_RELU_EN
            cnt_q   <= '0;
`endif
        end else begin
            count_q <= count_d;
            layer_q <= layer_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
            skip_q  <= skip_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
            wb_q    <= wb_d;
`ifdef NN_SEQ_RELU_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < MAX_LAYERS; i++) table_q[i] <= '0;
        end else if (cfg_wr) begin
            table_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        // Dimensions come straight from the table during LOAD, then from the
        // registered copy so they hold through the layer and after DONE.
        if (state_q == S_LOAD) begin
            bus.mm_m        = ent[29:20];
            bus.mm_n        = ent[19:10];
            bus.mm_k        = ent[9:0];
            bus.weight_base = ent[45:30];
        end else begin
            bus.mm_m        = m_q;
            bus.mm_n        = n_q;
            bus.mm_k        = k_q;
            bus.weight_base = wb_q;
        end
        bus.mm_start    = (state_q == S_START);
        bus.act_rd_bank = bank_q;
        bus.act_wr_bank = ~bank_q;
        bus.layer_idx   = layer_q;
        bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        bus.done        = (state_q == S_DONE);
        bus.err         = err_q;
`ifdef NN_SEQ_RELU_EN
        // relu_addr is the read address; the write in the same cycle targets
        // the address issued one cycle earlier (cnt_q-1). Addresses wrap at
        // 16 bits for m*n above 65536.
        bus.relu_addr    = '0;
        bus.relu_we      = 1'b0;
        bus.relu_wr_data = '0;
        if (state_q == S_RELU) begin
            bus.relu_addr = cnt_q[15:0];
            bus.relu_we   = (cnt_q != '0);
            if (cnt_q != '0)
                bus.relu_wr_data = bus.relu_rd_data[31] ? '0 : bus.relu_rd_data;
        end
`endif
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
module tb_nn_layer_sequencer;
    localparam int MAXL = 8;
    localparam int LW   = 3;
    localparam logic [54:0] RST_EXP = {6'b000001, 3'b000, 30'b0, 16'b0};

    typedef struct packed {
        logic [9:0]  m;
        logic [9:0]  n;
        logic [9:0]  k;
        logic [15:0] wb;
        logic        rd;
        logic        wr;
        logic [2:0]  li;
    } st_t;

    typedef struct {
        int          nl;
        logic [45:0] d0, d1, d2;
        int          nst;
        logic [2:0]  rd;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nn_layer_sequencer_if #(.LW(LW)) bus ();
    nn_layer_sequencer #(.MAX_LAYERS(MAXL), .LW(LW)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [45:0] desc(input int wb, input int m, input int n, input int k);
        return {16'(wb), 10'(m), 10'(n), 10'(k)};
    endfunction

    // ---------------- engine model: clears stale done one cycle after start ----------------
    int   lat = 30;
    int   eng_cnt;
    logic eng_busy, st_d1;
    always @(posedge clk) begin
        if (reset) begin
            bus.mm_done <= 1'b0;
            eng_busy    <= 1'b0;
            st_d1       <= 1'b0;
            eng_cnt     <= 0;
        end else begin
            st_d1 <= bus.mm_start;
            if (st_d1) begin
                bus.mm_done <= 1'b0;
                eng_busy    <= 1'b1;
                eng_cnt     <= lat;
            end else if (eng_busy) begin
                if (eng_cnt == 0) begin
                    bus.mm_done <= 1'b1;
                    eng_busy    <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

`ifdef NN_SEQ_RELU_EN
    logic signed [31:0] mem [256];
    logic [15:0] wa_d1;
    logic mem_init = 1'b0;
    always @(posedge clk) begin
        bus.relu_rd_data <= mem[bus.relu_addr[7:0]];
        wa_d1 <= bus.relu_addr;
        if (mem_init) begin
            mem[0] <= -32'sd5; mem[1] <= 32'sd7; mem[2] <= 32'sd0; mem[3] <= -32'sd1;
        end else if (bus.relu_we) begin
            mem[wa_d1[7:0]] <= bus.relu_wr_data;
        end
    end
`endif

    // ---------------- monitor ----------------
    st_t  got_q[$];
    int   done_cnt = 0;
    logic busy_seen = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy) busy_seen = 1'b1;
            if (bus.mm_start) begin
                st_t r;
                r.m = bus.mm_m; r.n = bus.mm_n; r.k = bus.mm_k; r.wb = bus.weight_base;
                r.rd = bus.act_rd_bank; r.wr = bus.act_wr_bank; r.li = bus.layer_idx;
                got_q.push_back(r);
                check("engine_idle_at_start", {63'b0, eng_busy}, 64'd0);
            end
            if (bus.done) begin
                done_cnt++;
                check("busy_at_done", {63'b0, bus.busy}, 64'd0);
                check("engine_idle_at_done", {63'b0, eng_busy}, 64'd0);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [45:0] shadow [MAXL];
    st_t  exp_q[$];
    logic exp_err;

    function automatic void model(input int nl);
        int bank = 0;
        exp_q.delete();
        exp_err = 1'b0;
        if (nl < 1 || nl > MAXL) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < nl; i++) begin
            logic [45:0] d = shadow[i];
            if (d[29:20] == 0 || d[19:10] == 0 || d[9:0] == 0) begin
                exp_err = 1'b1;
            end else begin
                st_t r;
                r.m = d[29:20]; r.n = d[19:10]; r.k = d[9:0]; r.wb = d[45:30];
                r.rd = bank[0]; r.wr = ~bank[0]; r.li = i[2:0];
                exp_q.push_back(r);
                bank ^= 1;
            end
        end
    endfunction

    task automatic wr_desc(input int idx, input logic [45:0] d);
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_addr = idx[LW-1:0]; bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        shadow[idx] = d;
    endtask

    task automatic do_run(input int nl, input bit same_wr, input logic [45:0] wd, input bit busy_wr);
        int cyc = 0;
        bit valid = (nl >= 1 && nl <= MAXL);
        got_q.delete();
        done_cnt  = 0;
        busy_seen = 1'b0;
        @(posedge clk); #1;
        bus.run = 1'b1; bus.num_layers = nl[LW:0];
        if (same_wr) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = wd;
            shadow[0] = wd;
        end
        @(posedge clk); #1;
        bus.run = 1'b0; bus.cfg_we = 1'b0;
        if (valid) begin
            while (done_cnt == 0 && cyc < 20000) begin
                if (busy_wr && got_q.size() > 0) begin
                    bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = desc(16'hDEAD, 9, 9, 9);
                    busy_wr = 1'b0;
                end
                @(posedge clk); #1;
                bus.cfg_we = 1'b0;
                cyc++;
            end
            if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
        end
        repeat (4) @(posedge clk);
        #1;
        model(nl);
        check("n_starts", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("start_rec", 64'(got_q[i]), 64'(exp_q[i]));
        check("done_pulses", 64'(done_cnt), valid ? 64'd1 : 64'd0);
        check("err", {63'b0, bus.err}, {63'b0, exp_err});
        if (!valid) check("busy_stays_low", {63'b0, busy_seen}, 64'd0);
    endtask

    function automatic logic [54:0] outs();
        return {bus.busy, bus.done, bus.err, bus.mm_start, bus.act_rd_bank, bus.act_wr_bank,
                bus.layer_idx, bus.mm_m, bus.mm_n, bus.mm_k, bus.weight_base};
    endfunction

    function automatic logic [45:0] rand_desc();
        int m = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 12));
        int n = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 12));
        int k = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 1023));
        return desc(int'($urandom_range(0, 65535)), m, n, k);
    endfunction

    vec_t vecs [7];

    initial begin
        int cyc;
        int nl;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.num_layers = '0; bus.run = 1'b0;
        for (int i = 0; i < MAXL; i++) shadow[i] = '0;

        vecs[0] = '{0, desc(0, 2, 3, 4), desc(0, 1, 1, 1), desc(0, 1, 1, 1), 0, 3'b000, 1'b1};
        vecs[1] = '{1, desc(0, 2, 3, 4), desc(0, 1, 1, 1), desc(0, 1, 1, 1), 1, 3'b000, 1'b0};
        vecs[2] = '{3, desc(0, 4, 3, 2), desc(24, 2, 4, 3), desc(36, 2, 2, 4), 3, 3'b010, 1'b0};
        vecs[3] = '{9, desc(0, 4, 3, 2), desc(24, 2, 4, 3), desc(36, 2, 2, 4), 0, 3'b000, 1'b1};
        vecs[4] = '{3, desc(0, 2, 2, 2), desc(8, 2, 2, 0), desc(16, 3, 3, 3), 2, 3'b010, 1'b1};
        vecs[5] = '{2, desc(0, 0, 1, 1), desc(4, 1, 1, 1), desc(0, 1, 1, 1), 1, 3'b000, 1'b1};
        vecs[6] = '{1, desc(16'h1234, 1023, 1, 1023), desc(0, 1, 1, 1), desc(0, 1, 1, 1), 1, 3'b000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(outs()), 64'(RST_EXP));
        reset = 1'b0;

        // table-driven runs
        for (int v = 0; v < 7; v++) begin
            wr_desc(0, vecs[v].d0);
            wr_desc(1, vecs[v].d1);
            wr_desc(2, vecs[v].d2);
            lat = 30;
            do_run(vecs[v].nl, 1'b0, '0, 1'b0);
            check("tbl_starts", 64'(got_q.size()), 64'(vecs[v].nst));
            for (int i = 0; i < vecs[v].nst && i < got_q.size(); i++)
                check("tbl_rd_bank", {63'b0, got_q[i].rd}, {63'b0, vecs[v].rd[i]});
            check("tbl_err", {63'b0, bus.err}, {63'b0, vecs[v].err});
        end

        // config write in the same cycle as run: run sees the new descriptor
        do_run(1, 1'b1, desc(16'h0777, 5, 6, 7), 1'b0);
        if (got_q.size() > 0) check("same_cycle_m", 64'(got_q[0].m), 64'd5);

        // config write while busy is dropped
        wr_desc(0, desc(16'h0100, 2, 2, 2));
        do_run(1, 1'b0, '0, 1'b1);
        do_run(1, 1'b0, '0, 1'b0);
        if (got_q.size() > 0) check("busy_write_ignored", 64'(got_q[0].m), 64'd2);

        // reset asserted while waiting on the engine
        wr_desc(0, desc(16'h0055, 3, 3, 3));
        lat = 30;
        got_q.delete();
        @(posedge clk); #1;
        bus.run = 1'b1; bus.num_layers = 4'd1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        cyc = 0;
        while (got_q.size() == 0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        check("start_before_reset", 64'(got_q.size()), 64'd1);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1 check("reset_async_outputs", 64'(outs()), 64'(RST_EXP));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < MAXL; i++) shadow[i] = '0;
        do_run(1, 1'b0, '0, 1'b0);   // cleared table -> zero-dim layer
        wr_desc(0, desc(16'h0042, 2, 2, 2));
        do_run(1, 1'b0, '0, 1'b0);

        // randomized runs against the model
        for (int it = 0; it < 25; it++) begin
            lat = int'($urandom_range(1, 12));
            for (int j = 0; j < MAXL; j++) wr_desc(j, rand_desc());
            if ($urandom_range(0, 7) == 0)
                nl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
            else
                nl = int'($urandom_range(1, MAXL));
            do_run(nl, 1'b0, '0, 1'b0);
        end

`ifdef NN_SEQ_RELU_EN
        @(posedge clk); #1 mem_init = 1'b1;
        @(posedge clk); #1 mem_init = 1'b0;
        wr_desc(0, desc(0, 2, 2, 1));
        lat = 5;
        do_run(1, 1'b0, '0, 1'b0);
        check("relu_out", 64'({mem[0], mem[1]}), 64'({32'sd0, 32'sd7}));
        check("relu_out_hi", 64'({mem[2], mem[3]}), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
